// File: rtl/key_loader.sv
// key_loader: assembles a masked key of programmable length k from 32-bit words.
// Optional build macro KEY_LOADER_ZEROIZE_EN clears key_o when the consumer acknowledges.
module key_loader #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 160,
  parameter int LEN_W  = 8
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  key_length_k_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic [KEY_W-1:0]  key_o,
  output logic [LEN_W-1:0]  key_length_k_o,
  output logic              key_valid_o,
  input  logic              key_ack_i,
  output logic              busy_o,
  output logic              error_o,
  output logic [1:0]        fsm_state
);

  localparam int NSLOT = KEY_W / WORD_W;
  localparam int CNT_W = $clog2(NSLOT + 1);

  // Handshakes: a word moves on a rising edge where word_valid_i && word_ready_o;
  // the key is handed over on a rising edge where key_valid_o && key_ack_i.
  // Neither ready nor valid depends combinationally on the partner's signal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W:0]   nwords_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] mask;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [LEN_W:0]   k_ext;
  logic [LEN_W:0]   nwords_full;
  logic             k_legal;
  logic             start_ok;
  logic             start_bad;
  logic             xfer;
  logic             last_xfer;

  // Length decode is done one bit wider so k = 255 cannot wrap the word count.
  always_comb begin
    k_ext       = {1'b0, key_length_k_i};
    k_legal     = (k_ext != '0) && (k_ext <= (LEN_W+1)'(KEY_W));
    nwords_full = (k_ext + (LEN_W+1)'(WORD_W - 1)) / (LEN_W+1)'(WORD_W);
    start_ok    = (state == IDLE) && start_i && k_legal;
    start_bad   = (state == IDLE) && start_i && !k_legal;
    xfer        = (state == LOAD) && word_valid_i;
    last_xfer   = xfer && ((LEN_W+1)'(cnt) == (nwords_q - (LEN_W+1)'(1)));
  end

  // Bits at or above the latched length are forced to zero as words land.
  always_comb begin
    mask = '0;
    for (int i = 0; i < KEY_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok)  state_nx = LOAD;
      LOAD:    if (last_xfer) state_nx = DONE;
      DONE:    if (key_ack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      key_q    <= '0;
      len_q    <= '0;
      cnt      <= '0;
      nwords_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        len_q    <= key_length_k_i;
        nwords_q <= nwords_full;
        key_q    <= '0;
        cnt      <= '0;
      end else if (xfer) begin
        for (int s = 0; s < NSLOT; s++) begin
          if (cnt == CNT_W'(s)) begin
            key_q[s*WORD_W +: WORD_W] <= word_i & mask[s*WORD_W +: WORD_W];
          end
        end
        cnt <= cnt + CNT_W'(1);
      end
`ifdef KEY_LOADER_ZEROIZE_EN
      else if ((state == DONE) && key_ack_i) begin
        key_q <= '0;
      end
`endif
    end
  end

  assign word_ready_o   = (state == LOAD);
  assign key_valid_o    = (state == DONE);
  assign busy_o         = (state != IDLE);
  assign error_o        = err_q;
  assign key_o          = key_q;
  assign key_length_k_o = len_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_key_loader.sv
// Scoreboarded bench for key_loader: directed loads from the test plan, then random loads.
module tb_key_loader;

  localparam int WORD_W = 32;
  localparam int KEY_W  = 160;
  localparam int LEN_W  = 8;
`ifdef KEY_LOADER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetb;
  logic              start;
  logic [LEN_W-1:0]  key_len;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              ack;
  logic              word_ready_o;
  logic [KEY_W-1:0]  key_o;
  logic [LEN_W-1:0]  key_length_k_o;
  logic              key_valid_o;
  logic              busy_o;
  logic              error_o;
  logic [1:0]        fsm_state;

  key_loader #(.WORD_W(WORD_W), .KEY_W(KEY_W), .LEN_W(LEN_W)) dut (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .key_length_k_i(key_len),
    .word_i(word), .word_valid_i(word_valid), .word_ready_o(word_ready_o),
    .key_o(key_o), .key_length_k_o(key_length_k_o), .key_valid_o(key_valid_o),
    .key_ack_i(ack), .busy_o(busy_o), .error_o(error_o), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [KEY_W+LEN_W-1:0] exp_q[$];
  int                     err_exp_q[$];
  logic [KEY_W-1:0]       model_key;
  logic [LEN_W-1:0]       model_len;

  task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: bit i of the key is stream bit i when i < k, otherwise zero.
  function automatic logic [KEY_W-1:0] ref_key(input logic [KEY_W-1:0] flat, input int k);
    logic [KEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_W; i++) if (i < k) r[i] = flat[i];
    return r;
  endfunction

  // scoreboard monitor
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [KEY_W+LEN_W-1:0] e;
    if (key_valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL key_unexpected: got key_valid_o=1 expected no pending key");
      end else begin
        e = exp_q.pop_front();
        check("key_value", key_o, e[KEY_W+LEN_W-1:LEN_W]);
        check("key_length", KEY_W'(key_length_k_o), KEY_W'(e[LEN_W-1:0]));
      end
    end
    if (key_valid_o) check("ready_low_in_done", KEY_W'(word_ready_o), '0);
    if (error_o) begin
      if (err_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL error_unexpected: got error_o=1 expected 0");
      end else begin
        void'(err_exp_q.pop_front());
        check("error_busy", KEY_W'(busy_o), '0);
      end
    end
    prev_valid = key_valid_o;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_key"}, key_o, '0);
    check({tag, "_len"}, KEY_W'(key_length_k_o), '0);
    check({tag, "_valid"}, KEY_W'(key_valid_o), '0);
    check({tag, "_ready"}, KEY_W'(word_ready_o), '0);
    check({tag, "_busy"}, KEY_W'(busy_o), '0);
    check({tag, "_error"}, KEY_W'(error_o), '0);
    check({tag, "_state"}, KEY_W'(fsm_state), '0);
  endtask

  task automatic do_reset();
    resetb = 1'b0; start = 1'b0; word_valid = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset");
    resetb = 1'b1;
    model_key = '0;
    model_len = '0;
    @(posedge clk); #1;
  endtask

  // driver: mode 0 back-to-back words, 1 valid toggling, 2 random valid
  task automatic do_load(input int k, input logic [KEY_W-1:0] flat, input int mode,
                         input int abort_at, input int ack_dly);
    int nw;
    int idx;
    int cyc;
    logic [KEY_W-1:0] exp;
    nw  = (k + WORD_W - 1) / WORD_W;
    idx = 0;
    cyc = 0;
    exp = ref_key(flat, k);
    exp_q.push_back({exp, LEN_W'(k)});
    start = 1'b1; key_len = LEN_W'(k);
    @(posedge clk); #1;
    while (idx < nw) begin
      if (cyc >= 400) begin
        checks++; failures++;
        $display("FAIL load_timeout: got %0d transfers expected %0d", idx, nw);
        break;
      end
      word = flat[idx*WORD_W +: WORD_W];
      case (mode)
        0:       word_valid = 1'b1;
        1:       word_valid = (cyc % 2 == 0);
        default: word_valid = ($urandom_range(0, 2) != 0);
      endcase
      start   = ($urandom_range(0, 3) == 0);
      key_len = LEN_W'($urandom);
      @(negedge clk);
      if (cyc == 0) check("ready_after_start", KEY_W'(word_ready_o), KEY_W'(1));
      if (word_valid && word_ready_o) idx++;
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && idx == abort_at) break;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      resetb = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("abort");
      resetb = 1'b1; word_valid = 1'b0;
      void'(exp_q.pop_back());
      model_key = '0;
      model_len = '0;
      @(posedge clk); #1;
      return;
    end
    word_valid = 1'b1;
    word = $urandom;
    @(negedge clk);
    check("valid_latency", KEY_W'(key_valid_o), KEY_W'(1));
    for (int d = 0; d < ack_dly; d++) begin
      start   = $urandom_range(0, 1);
      key_len = LEN_W'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      check("valid_held", KEY_W'(key_valid_o), KEY_W'(1));
    end
    ack   = 1'b1;
    start = $urandom_range(0, 1);
    key_len = LEN_W'($urandom_range(1, KEY_W));
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0; word_valid = 1'b0;
    model_key = ZEROIZE ? '0 : exp;
    model_len = LEN_W'(k);
    @(negedge clk);
    check("idle_after_ack_valid", KEY_W'(key_valid_o), '0);
    check("idle_after_ack_busy", KEY_W'(busy_o), '0);
    check("key_after_ack", key_o, model_key);
    check("len_after_ack", KEY_W'(key_length_k_o), KEY_W'(model_len));
    @(posedge clk); #1;
  endtask

  task automatic do_err(input int k);
    err_exp_q.push_back(k);
    start = 1'b1; key_len = LEN_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("error_pulse", KEY_W'(error_o), KEY_W'(1));
    check("error_key_kept", key_o, model_key);
    check("error_len_kept", KEY_W'(key_length_k_o), KEY_W'(model_len));
    @(posedge clk); #1;
    @(negedge clk);
    check("error_one_cycle", KEY_W'(error_o), '0);
    check("error_stays_idle", KEY_W'(busy_o), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] flat;
    int k;
    key_len = '0; word = '0;
    do_reset();

    flat = '0;
    flat[127:0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    do_load(128, flat, 0, -1, 0);
    do_load(160, {KEY_W{1'b1}}, 1, -1, 1);
    do_load(100, {KEY_W{1'b1}}, 0, -1, 2);
    do_err(0);
    do_err(161);
    flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
    do_load(160, flat, 0, 2, 0);
    flat = '0;
    flat[31:0] = 32'hDEADBEEF;
    do_load(32, flat, 0, -1, 0);
    flat = '0;
    flat[63:0] = 64'h22222222_11111111;
    do_load(64, flat, 0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
      k = $urandom_range(1, KEY_W);
      if ($urandom_range(0, 4) == 0) do_err($urandom_range(0, 1) == 0 ? 0 : $urandom_range(KEY_W + 1, 255));
      do_load(k, flat, 2, -1, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_queue_drained", KEY_W'(exp_q.size()), '0);
    check("err_queue_drained", KEY_W'(err_exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
